// File: rtl/pc_seq_if.sv
// Request/response bundle between the EX hazard/branch logic and the next-PC sequencer.
// Perf counter signals exist only when PC_SEQ_PERF_EN is defined.
interface pc_seq_if #(
    parameter int ISIZE = 16
);
    logic             stall_i;
    logic             br_taken_i;
    logic [ISIZE-1:0] br_target_i;
    logic             jmp_i;
    logic [ISIZE-1:0] jmp_target_i;
    logic             halt_i;
    logic             resume_i;
    logic [ISIZE-1:0] pc_o;
    logic             pc_valid_o;
    logic             flush_o;
    logic [1:0]       state_o;
`ifdef PC_SEQ_PERF_EN
    logic [15:0]      redirect_cnt_o;
    logic [15:0]      stall_cnt_o;
`endif

    // master: the sequencer, which owns the PC
    modport master (
        input  stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, halt_i, resume_i,
`ifdef PC_SEQ_PERF_EN
        output redirect_cnt_o, stall_cnt_o,
`endif
        output pc_o, pc_valid_o, flush_o, state_o
    );

    modport slave (
        output stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, halt_i, resume_i,
`ifdef PC_SEQ_PERF_EN
        input  redirect_cnt_o, stall_cnt_o,
`endif
        input  pc_o, pc_valid_o, flush_o, state_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential advance, stall hold, branch/jump redirect, halt/resume.
// Optional PC_SEQ_PERF_EN adds saturating redirect and stall counters.
//
//   state    | meaning
//   RESET    | PC at reset vector, no fetch yet
//   RUN      | fetching; advance, hold or redirect per cycle
//   REDIRECT | one bubble cycle after a taken branch/jump, PC holds target
//   HALT     | fetch stopped at held PC until resume
module pc_sequencer #(
    parameter int               ISIZE     = 16,
    parameter logic [ISIZE-1:0] RESET_VEC = '0
) (
    input logic      clk,
    input logic      rst,
    pc_seq_if.master bus
);
    typedef enum logic [1:0] {
        ST_RESET    = 2'b00,
        ST_RUN      = 2'b01,
        ST_REDIRECT = 2'b10,
        ST_HALT     = 2'b11
    } state_t;

    state_t           state;
    logic [ISIZE-1:0] pc;
    logic             pc_valid;
    logic             flush;
`ifdef PC_SEQ_PERF_EN
    logic [15:0]      redirect_cnt;
    logic [15:0]      stall_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RESET;
            pc       <= RESET_VEC;
            pc_valid <= 1'b0;
            flush    <= 1'b0;
`ifdef PC_SEQ_PERF_EN
            redirect_cnt <= '0;
            stall_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_RESET: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                    flush    <= 1'b0;
                end
                ST_RUN: begin
                    if (bus.halt_i) begin
                        state    <= ST_HALT;
                        pc_valid <= 1'b0;
                        flush    <= 1'b1;
                    end else if (bus.br_taken_i || bus.jmp_i) begin
                        // branch outranks jump when both resolve together
                        pc       <= bus.br_taken_i ? bus.br_target_i : bus.jmp_target_i;
                        state    <= ST_REDIRECT;
                        pc_valid <= 1'b0;
                        flush    <= 1'b1;
`ifdef PC_SEQ_PERF_EN
                        if (redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
`endif
                    end else if (bus.stall_i) begin
                        pc_valid <= 1'b1;
                        flush    <= 1'b0;
`ifdef PC_SEQ_PERF_EN
                        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
                    end else begin
                        pc       <= pc + ISIZE'(1);
                        pc_valid <= 1'b1;
                        flush    <= 1'b0;
                    end
                end
                ST_REDIRECT: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                    flush    <= 1'b0;
                end
                ST_HALT: begin
                    flush <= 1'b0;
                    if (bus.resume_i) begin
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                    end else begin
                        pc_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RESET;
                    pc       <= RESET_VEC;
                    pc_valid <= 1'b0;
                    flush    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o       = pc;
    assign bus.pc_valid_o = pc_valid;
    assign bus.flush_o    = flush;
    assign bus.state_o    = state;
`ifdef PC_SEQ_PERF_EN
    assign bus.redirect_cnt_o = redirect_cnt;
    assign bus.stall_cnt_o    = stall_cnt;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal pins plus a
// randomized phase compared every cycle against a behavioural model.
module tb_pc_sequencer;
    localparam int          ISIZE = 16;
    localparam logic [15:0] RVEC  = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_seq_if #(.ISIZE(ISIZE)) bus ();

    pc_sequencer #(.ISIZE(ISIZE), .RESET_VEC(RVEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: a mode plus the architecturally visible values
    localparam logic [1:0] M_RESET = 2'b00, M_RUN = 2'b01, M_REDIR = 2'b10, M_HALT = 2'b11;
    logic [1:0]  m_mode  = M_RESET;
    logic [15:0] m_pc    = RVEC;
    logic        m_valid = 1'b0;
    logic        m_flush = 1'b0;
    int          m_rcnt  = 0;
    int          m_scnt  = 0;
    bit          m_known = 1'b0;
    logic        prev_flush = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_RESET; m_pc = RVEC; m_valid = 1'b0; m_flush = 1'b0;
            m_rcnt = 0; m_scnt = 0; m_known = 1'b1;
        end else if (m_known) begin
            m_flush = 1'b0;
            if (m_mode == M_RESET || m_mode == M_REDIR) begin
                m_mode = M_RUN; m_valid = 1'b1;
            end else if (m_mode == M_HALT) begin
                m_valid = 1'b0;
                if (bus.resume_i) begin m_mode = M_RUN; m_valid = 1'b1; end
            end else if (bus.halt_i) begin
                m_mode = M_HALT; m_valid = 1'b0; m_flush = 1'b1;
            end else if (bus.br_taken_i) begin
                m_pc = bus.br_target_i; m_mode = M_REDIR; m_valid = 1'b0; m_flush = 1'b1;
                m_rcnt = (m_rcnt < 65535) ? m_rcnt + 1 : 65535;
            end else if (bus.jmp_i) begin
                m_pc = bus.jmp_target_i; m_mode = M_REDIR; m_valid = 1'b0; m_flush = 1'b1;
                m_rcnt = (m_rcnt < 65535) ? m_rcnt + 1 : 65535;
            end else if (bus.stall_i) begin
                m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
            end else begin
                m_pc = 16'((int'(m_pc) + 1) % 65536);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("pc", 32'(bus.pc_o), 32'(m_pc));
            chk("valid", 32'(bus.pc_valid_o), 32'(m_valid));
            chk("flush", 32'(bus.flush_o), 32'(m_flush));
            chk("state", 32'(bus.state_o), 32'(m_mode));
`ifdef PC_SEQ_PERF_EN
            chk("redirect_cnt", 32'(bus.redirect_cnt_o), 32'(m_rcnt));
            chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_scnt));
`endif
            chk("flush_single", 32'(prev_flush && bus.flush_o), 32'd0);
            prev_flush = bus.flush_o;
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.stall_i = 0; bus.br_taken_i = 0; bus.jmp_i = 0;
        bus.halt_i = 0; bus.resume_i = 0;
    endtask

    task automatic pin(input string name, input logic [15:0] pc, input logic v,
                       input logic f, input logic [1:0] st);
        chk({name, ".pc"}, 32'(bus.pc_o), 32'(pc));
        chk({name, ".valid"}, 32'(bus.pc_valid_o), 32'(v));
        chk({name, ".flush"}, 32'(bus.flush_o), 32'(f));
        chk({name, ".state"}, 32'(bus.state_o), 32'(st));
    endtask

    initial begin
        idle();
        bus.br_target_i = '0; bus.jmp_target_i = '0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        pin("reset", 16'h0000, 1'b0, 1'b0, 2'b00);
        cyc(); pin("first_fetch", 16'h0000, 1'b1, 1'b0, 2'b01);
        cyc(); pin("seq1", 16'h0001, 1'b1, 1'b0, 2'b01);
        cyc(); pin("seq2", 16'h0002, 1'b1, 1'b0, 2'b01);
        cyc(); pin("seq3", 16'h0003, 1'b1, 1'b0, 2'b01);
        cyc(2); pin("at5", 16'h0005, 1'b1, 1'b0, 2'b01);

        bus.stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(); pin("stall_hold", 16'h0005, 1'b1, 1'b0, 2'b01);
        end
        bus.stall_i = 0;
        cyc(); pin("after_stall", 16'h0006, 1'b1, 1'b0, 2'b01);
`ifdef PC_SEQ_PERF_EN
        chk("stall_cnt_lit", 32'(bus.stall_cnt_o), 32'd3);
`endif
        cyc(2); pin("at8", 16'h0008, 1'b1, 1'b0, 2'b01);

        bus.br_taken_i = 1; bus.br_target_i = 16'h0040;
        bus.jmp_i = 1; bus.jmp_target_i = 16'h0777; bus.stall_i = 1;
        cyc(); idle();
        pin("br_prio", 16'h0040, 1'b0, 1'b1, 2'b10);
        cyc(); pin("redir_done", 16'h0040, 1'b1, 1'b0, 2'b01);
        cyc(); pin("target_plus1", 16'h0041, 1'b1, 1'b0, 2'b01);

        bus.jmp_i = 1; bus.jmp_target_i = 16'hFFFF;
        cyc(); idle();
        cyc(); pin("at_ffff", 16'hFFFF, 1'b1, 1'b0, 2'b01);
        cyc(); pin("wrap", 16'h0000, 1'b1, 1'b0, 2'b01);

        bus.jmp_i = 1; bus.jmp_target_i = 16'h0010;
        cyc(); idle();
        cyc(); pin("at10", 16'h0010, 1'b1, 1'b0, 2'b01);
        bus.halt_i = 1;
        cyc(); idle();
        pin("halt", 16'h0010, 1'b0, 1'b1, 2'b11);
        bus.br_taken_i = 1; bus.br_target_i = 16'h0099;
        cyc(); idle();
        pin("halt_ignore_br", 16'h0010, 1'b0, 1'b0, 2'b11);
        bus.resume_i = 1;
        cyc(); idle();
        pin("resume", 16'h0010, 1'b1, 1'b0, 2'b01);
        cyc(); pin("resume_seq", 16'h0011, 1'b1, 1'b0, 2'b01);

        bus.br_taken_i = 1; bus.br_target_i = 16'h0123;
        cyc(); idle();
        pin("redir_before_rst", 16'h0123, 1'b0, 1'b1, 2'b10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pin("rst_in_redir", RVEC, 1'b0, 1'b0, 2'b00);
`ifdef PC_SEQ_PERF_EN
        chk("rcnt_clr", 32'(bus.redirect_cnt_o), 32'd0);
        chk("scnt_clr", 32'(bus.stall_cnt_o), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            bus.halt_i      = ($urandom_range(0, 99) < 4);
            bus.br_taken_i  = ($urandom_range(0, 9) == 0);
            bus.jmp_i       = ($urandom_range(0, 9) == 0);
            bus.stall_i     = ($urandom_range(0, 4) == 0);
            bus.resume_i    = ($urandom_range(0, 2) == 0);
            bus.br_target_i = 16'($urandom);
            bus.jmp_target_i = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rst             = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; idle();
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the 4-stage pipeline. It owns the fetch program counter and decides each cycle whether the PC advances sequentially, holds for a hazard stall, or redirects to a branch or jump target. It also halts and resumes fetch. It sits between the hazard/branch-resolution logic in EX and the instruction memory address port in IF. It also drives the IF/ID flush request.

Parameters:
- ISIZE, 16, width of the instruction address / PC in bits
- RESET_VEC, 0, PC value loaded on reset (ISIZE bits)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall_i  input  1  load-use hazard; hold PC this cycle
- br_taken_i  input  1  branch resolved taken in EX
- br_target_i  input  ISIZE  branch target address
- jmp_i  input  1  unconditional jump resolved
- jmp_target_i  input  ISIZE  jump target address
- halt_i  input  1  halt instruction reached EX
- resume_i  input  1  external restart request
- pc_o  output  ISIZE  current fetch address
- pc_valid_o  output  1  pc_o is a real fetch; 0 means insert a bubble
- flush_o  output  1  one-cycle flush of IF/ID and ID/EX
- state_o  output  2  FSM state, for debug

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. Reset values: pc_o=RESET_VEC, pc_valid_o=0, flush_o=0, state=RESET. rst overrides every other input in every state.
- FSM encoding: RESET=2'b00, RUN=2'b01, REDIRECT=2'b10, HALT=2'b11.
- RESET: the next cycle always moves to RUN with pc_valid_o=1. pc_o stays at RESET_VEC, so the first fetch is RESET_VEC, not RESET_VEC+1.
- RUN: one request acts per cycle, in fixed priority halt_i > br_taken_i > jmp_i > stall_i > sequential.
  - halt_i: go to HALT; pc_o holds; pc_valid_o<=0; flush_o<=1.
  - br_taken_i: pc_o<=br_target_i; flush_o<=1; pc_valid_o<=0; go to REDIRECT. jmp_i and stall_i are ignored that cycle.
  - jmp_i: same as a branch, using jmp_target_i.
  - stall_i: pc_o holds; pc_valid_o stays 1; flush_o<=0.
  - none of the above: pc_o<=pc_o+1, modulo 2^ISIZE. All-ones wraps to 0 with no flag.
- REDIRECT: lasts exactly one cycle, then returns to RUN with pc_valid_o<=1 and flush_o<=0. pc_o holds the target, so the target is fetched first. All request inputs except rst are ignored in this state.
- HALT: pc_o holds; pc_valid_o=0; flush_o returns to 0 after one cycle. resume_i moves to RUN with pc_valid_o<=1, and fetch restarts at the held PC. br/jmp/stall/halt are ignored while in HALT.
- Latency: every decision takes effect at the next clk edge; all outputs are registered. There is no combinational path from inputs to outputs.
- flush_o is a single-cycle pulse for each redirect or halt. It is never asserted for two consecutive cycles.
- rst in REDIRECT or HALT returns to RESET with all outputs at reset values on the next edge.

Optional Feature:
Macro PC_SEQ_PERF_EN.
- Defined:
  - Adds output redirect_cnt_o (16 bits): increments once per accepted branch or jump.
  - Adds output stall_cnt_o (16 bits): increments once per RUN cycle that holds due to stall_i.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Not defined: the ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- rst high 2 cycles, then low -> cycle 1: state RESET, pc_o=0, pc_valid_o=0. Cycle 2: RUN, pc_o=0, valid=1. Then pc_o=1,2,3 on successive edges.
- In RUN at pc_o=5, stall_i high 3 cycles -> pc_o stays 5 for 3 cycles with valid=1, then 6; stall_cnt_o=3 if PC_SEQ_PERF_EN is defined.
- At pc_o=8, pulse br_taken_i=1 with br_target_i=16'h0040, and assert jmp_i=1 and stall_i=1 in the same cycle -> branch wins. Next edge: pc_o=0x0040, flush_o=1, valid=0, state REDIRECT. Following edge: valid=1, flush_o=0, pc_o=0x0040. Then 0x0041.
- Preload pc_o=16'hFFFF by jmp_target_i=16'hFFFF, run one sequential cycle -> pc_o=16'h0000, no error.
- halt_i at pc_o=0x0010 -> HALT, valid=0, flush_o pulses 1 cycle. br_taken_i during HALT has no effect. resume_i -> RUN, pc_o=0x0010, valid=1.
- rst asserted during REDIRECT -> next edge: pc_o=RESET_VEC, valid=0, flush_o=0, state_o=2'b00; counters cleared.
